ysyx_25040101_pc_reg: RTL and testbench

- Sequential consumer of next_pc_o from ysyx_25040101_pc_plus.
- Holds the architectural PC and drives fetch requests to the IFU with a valid/ready handshake.
- Captures the returned instruction and presents it to decode.
- Loads the next PC on the commit strobe from ctrl_unit; counts retired instructions.

---
 rtl/ysyx_25040101_pkg.sv | 14 +
 rtl/ysyx_25040101_pc_reg.sv | 92 +++++++++
 tb/tb_ysyx_25040101_pc_reg.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040101_pkg.sv
// rtl/ysyx_25040101_pkg.sv - shared types and constants for the PC register slice
package ysyx_25040101_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } pc_state_t;

endpackage

// File: rtl/ysyx_25040101_pc_reg.sv
// rtl/ysyx_25040101_pc_reg.sv - architectural PC, IFU fetch handshake, retire counter (option: YSYX_25040101_MISALIGN_CHECK_EN)
module ysyx_25040101_pc_reg
  import ysyx_25040101_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [31:0]       next_pc_i,
  input  logic              commit_i,
  output logic [31:0]       pc_o,
  output logic              fetch_req_o,
  input  logic              fetch_ready_i,
  input  logic              resp_valid_i,
  input  logic [INST_W-1:0] resp_inst_i,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic [CNT_W-1:0]  retire_cnt_o,
  output logic              misalign_o
);

  pc_state_t state;

  // Request is valid exactly while the FSM sits in FETCH, so pc_o and the
  // request stay stable until the IFU takes them.
  assign fetch_req_o = (state == S_FETCH);

`ifdef YSYX_25040101_MISALIGN_CHECK_EN
  logic misalign_q;
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  // Fetch/execute sequencing, PC update and retire counting on commit.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= S_FETCH;
      pc_o         <= RESET_PC;
      inst_o       <= '0;
      inst_valid_o <= 1'b0;
      retire_cnt_o <= '0;
`ifdef YSYX_25040101_MISALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          // A response in the handshake cycle is deliberately not looked at.
          if (fetch_ready_i) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (resp_valid_i) begin
            inst_o       <= resp_inst_i;
            inst_valid_o <= 1'b1;
            state        <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (commit_i) begin
            retire_cnt_o <= retire_cnt_o + CNT_W'(1);
            inst_valid_o <= 1'b0;
`ifdef YSYX_25040101_MISALIGN_CHECK_EN
            // A misaligned target still retires the current instruction but
            // keeps the old PC and parks the core until reset.
            if (next_pc_i[1:0] != 2'b00) begin
              misalign_q <= 1'b1;
              state      <= S_HALT;
            end else begin
              pc_o  <= next_pc_i;
              state <= S_FETCH;
            end
`else
            pc_o  <= next_pc_i;
            state <= S_FETCH;
`endif
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040101_pc_reg.sv
// tb/tb_ysyx_25040101_pc_reg.sv - directed self-checking bench for ysyx_25040101_pc_reg
module tb_ysyx_25040101_pc_reg;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] next_pc_i;
  logic        commit_i;
  logic [31:0] pc_o;
  logic        fetch_req_o;
  logic        fetch_ready_i;
  logic        resp_valid_i;
  logic [31:0] resp_inst_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic [63:0] retire_cnt_o;
  logic        misalign_o;

  int n_checks = 0;
  int n_fails  = 0;

  ysyx_25040101_pc_reg dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .next_pc_i     (next_pc_i),
    .commit_i      (commit_i),
    .pc_o          (pc_o),
    .fetch_req_o   (fetch_req_o),
    .fetch_ready_i (fetch_ready_i),
    .resp_valid_i  (resp_valid_i),
    .resp_inst_i   (resp_inst_i),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o),
    .retire_cnt_o  (retire_cnt_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n_i       = 1'b0;
    next_pc_i     = 32'h0;
    commit_i      = 1'b0;
    fetch_ready_i = 1'b0;
    resp_valid_i  = 1'b0;
    resp_inst_i   = 32'h0;
    step();
    step();

    check("rst_pc",        64'(pc_o),         64'h8000_0000);
    check("rst_fetch_req", 64'(fetch_req_o),  64'h1);
    check("rst_inst",      64'(inst_o),       64'h0);
    check("rst_inst_vld",  64'(inst_valid_o), 64'h0);
    check("rst_retire",    retire_cnt_o,      64'h0);
    check("rst_misalign",  64'(misalign_o),   64'h0);

    // Cycle 0 after release: immediate handshake.
    rst_n_i       = 1'b1;
    fetch_ready_i = 1'b1;
    step();
    check("hs0_wait_req",  64'(fetch_req_o),  64'h0);
    check("hs0_pc",        64'(pc_o),         64'h8000_0000);

    // WAIT: spurious commit, no response yet.
    fetch_ready_i = 1'b0;
    commit_i      = 1'b1;
    next_pc_i     = 32'h1234_5678;
    step();
    commit_i = 1'b0;
    check("wait_commit_pc",  64'(pc_o),         64'h8000_0000);
    check("wait_commit_cnt", retire_cnt_o,      64'h0);
    check("wait_no_vld",     64'(inst_valid_o), 64'h0);

    // Response on the second WAIT cycle.
    resp_valid_i = 1'b1;
    resp_inst_i  = 32'h0010_0093;
    step();
    resp_valid_i = 1'b0;
    resp_inst_i  = 32'hdead_beef;
    check("resp_inst",     64'(inst_o),       64'h0010_0093);
    check("resp_vld",      64'(inst_valid_o), 64'h1);
    step();
    step();
    check("exec_hold_inst", 64'(inst_o),       64'h0010_0093);
    check("exec_hold_vld",  64'(inst_valid_o), 64'h1);
    check("exec_no_req",    64'(fetch_req_o),  64'h0);

    // Commit to 0x8000_0004.
    commit_i  = 1'b1;
    next_pc_i = 32'h8000_0004;
    step();
    commit_i  = 1'b0;
    next_pc_i = 32'h0;
    check("commit_pc",     64'(pc_o),         64'h8000_0004);
    check("commit_cnt",    retire_cnt_o,      64'h1);
    check("commit_req",    64'(fetch_req_o),  64'h1);
    check("commit_vld",    64'(inst_valid_o), 64'h0);

    // IFU stalls three cycles; stray response and commit are dropped.
    resp_valid_i = 1'b1;
    commit_i     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_req", 64'(fetch_req_o), 64'h1);
      check("stall_pc",  64'(pc_o),        64'h8000_0004);
    end
    commit_i = 1'b0;
    check("stall_cnt", retire_cnt_o, 64'h1);

    // Handshake with a simultaneous response: response must be ignored.
    fetch_ready_i = 1'b1;
    resp_inst_i   = 32'h0bad_0bad;
    step();
    fetch_ready_i = 1'b0;
    resp_valid_i  = 1'b0;
    check("hs_req",        64'(fetch_req_o),  64'h0);
    check("hs_resp_drop",  64'(inst_valid_o), 64'h0);
    check("hs_inst_keep",  64'(inst_o),       64'h0010_0093);

    // Minimum-latency response.
    resp_valid_i = 1'b1;
    resp_inst_i  = 32'h0020_0113;
    step();
    resp_valid_i = 1'b0;
    check("resp2_inst", 64'(inst_o),       64'h0020_0113);
    check("resp2_vld",  64'(inst_valid_o), 64'h1);

    // Commit to a misaligned target.
    commit_i  = 1'b1;
    next_pc_i = 32'h8000_0002;
    step();
    commit_i  = 1'b0;
    check("mis_cnt", retire_cnt_o,      64'h2);
    check("mis_vld", 64'(inst_valid_o), 64'h0);
`ifdef YSYX_25040101_MISALIGN_CHECK_EN
    check("mis_flag", 64'(misalign_o),  64'h1);
    check("mis_pc",   64'(pc_o),        64'h8000_0004);
    fetch_ready_i = 1'b1;
    resp_valid_i  = 1'b1;
    commit_i      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_req", 64'(fetch_req_o), 64'h0);
      check("halt_pc",  64'(pc_o),        64'h8000_0004);
    end
    check("halt_cnt", retire_cnt_o, 64'h2);
    commit_i     = 1'b0;
    resp_valid_i = 1'b0;
`else
    check("mis_flag", 64'(misalign_o),  64'h0);
    check("mis_pc",   64'(pc_o),        64'h8000_0002);
    check("mis_req",  64'(fetch_req_o), 64'h1);
`endif

    // Reset while waiting, then a stale response after release.
    rst_n_i       = 1'b0;
    fetch_ready_i = 1'b0;
    step();
    rst_n_i       = 1'b1;
    fetch_ready_i = 1'b1;
    step();
    check("rw_in_wait", 64'(fetch_req_o), 64'h0);
    rst_n_i       = 1'b0;
    fetch_ready_i = 1'b0;
    step();
    rst_n_i      = 1'b1;
    resp_valid_i = 1'b1;
    resp_inst_i  = 32'h0030_0193;
    step();
    resp_valid_i = 1'b0;
    check("stale_pc",     64'(pc_o),         64'h8000_0000);
    check("stale_vld",    64'(inst_valid_o), 64'h0);
    check("stale_inst",   64'(inst_o),       64'h0);
    check("stale_req",    64'(fetch_req_o),  64'h1);
    check("stale_cnt",    retire_cnt_o,      64'h0);
    check("stale_mis",    64'(misalign_o),   64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
